// File: rtl/hqm_mem_pg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hqm_mem_pg_pkg
//  Description : Shared types and constants for the power-gated RF wrapper.
//                The power sequencer state encoding and helpers that map
//                each state to its power-chain and isolation controls.
//  Revision    : 1.0  initial release
// ============================================================================
package hqm_mem_pg_pkg;

    // Width of the saturating dropped-access counter
    localparam int DROP_CNT_W = 8;

    // Power sequencer states
    typedef enum logic [2:0] {
        OFF   = 3'd0,
        PWRUP = 3'd1,
        WAKE  = 3'd2,
        ON    = 3'd3,
        DRAIN = 3'd4,
        ISOL  = 3'd5,
        PWRDN = 3'd6
    } pg_state_t;

    // Output isolation stays released only while the array can drive data
    function automatic logic pg_isol(input pg_state_t s);
        return !((s == ON) || (s == DRAIN));
    endfunction

    // Power chain enable (active low) is off only at rest and during ramp-down
    function automatic logic pg_en_b(input pg_state_t s);
        return (s == OFF) || (s == PWRDN);
    endfunction

endpackage : hqm_mem_pg_pkg
`default_nettype wire

// File: rtl/hqm_mem_pg_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : hqm_mem_pg_fsm
//  Description : Array power sequencer. Walks the power chain up, waits the
//                wake delay, releases isolation, and on request drains,
//                isolates and powers the array back down. All outputs are
//                registered and derived from the next state.
//  Revision    : 1.0  initial release
// ============================================================================
module hqm_mem_pg_fsm
    import hqm_mem_pg_pkg::*;
#(
    parameter int WAKE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr_req,
    input  logic pwr_enable_b_in,
    output logic pwr_ack,
    output logic isol,
    output logic en_b,
    output logic clr_valid
);

    // Terminal wake count, the cycle before the array becomes usable
    localparam logic [7:0] c_wake_last = 8'(WAKE_CYCLES - 1);

    pg_state_t  r_state;
    pg_state_t  w_state_nxt;
    logic [7:0] r_wake_cnt;

    // Next-state selection; a dropped request aborts the ramp-up, while
    // the ramp-down always completes before honouring a new request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OFF:     if (pwr_req) w_state_nxt = PWRUP;
            PWRUP:   if (!pwr_req)                       w_state_nxt = ISOL;
                     else if (!pwr_enable_b_in)          w_state_nxt = WAKE;
            WAKE:    if (!pwr_req)                       w_state_nxt = ISOL;
                     else if (r_wake_cnt == c_wake_last) w_state_nxt = ON;
            ON:      if (!pwr_req) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = ISOL;
            ISOL:    w_state_nxt = PWRDN;
            PWRDN:   if (pwr_enable_b_in) w_state_nxt = OFF;
            default: w_state_nxt = OFF;
        endcase
    end

    // State, wake counter and registered controls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= OFF;
            r_wake_cnt <= 8'd0;
            pwr_ack    <= 1'b0;
            isol       <= 1'b1;
            en_b       <= 1'b1;
            clr_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wake_cnt <= ((r_state == WAKE) && (w_state_nxt == WAKE)) ? r_wake_cnt + 8'd1 : 8'd0;
            pwr_ack    <= (w_state_nxt == ON);
            isol       <= pg_isol(w_state_nxt);
            en_b       <= pg_en_b(w_state_nxt);
            clr_valid  <= (r_state == PWRDN) && (w_state_nxt == OFF);
        end
    end

endmodule : hqm_mem_pg_fsm
`default_nettype wire

// File: rtl/hqm_system_mem_rf_pg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hqm_system_mem_rf_pg_seq
//  Description : Single-clock power-gated register file with built-in power
//                sequencer, per-entry parity with error injection, optional
//                write-first bypass and a saturating count of accesses that
//                arrive while the array is unusable.
//  Revision    : 1.0  initial release
// ============================================================================
module hqm_system_mem_rf_pg_seq
    import hqm_mem_pg_pkg::*;
#(
    parameter  int DEPTH       = 4,
    parameter  int DWIDTH      = 17,
    parameter  int WAKE_CYCLES = 8,
    parameter  int PAR_EN      = 1,
    parameter  int BYPASS_EN   = 1,
    localparam int AWIDTH      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AWIDTH-1:0]     waddr,
    input  logic [DWIDTH-1:0]     wdata,
    input  logic                  par_inj,
    input  logic                  re,
    input  logic [AWIDTH-1:0]     raddr,
    output logic [DWIDTH-1:0]     rdata,
    output logic                  rvalid,
    output logic                  rpar_err,
    input  logic                  pwr_req,
    output logic                  pwr_ack,
    output logic                  pgcb_isol_en,
    output logic                  pwr_enable_b_out,
    input  logic                  pwr_enable_b_in,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [AWIDTH:0] c_depth     = (AWIDTH+1)'(DEPTH);
    localparam bit              c_par_en    = (PAR_EN != 0);
    localparam bit              c_bypass_en = (BYPASS_EN != 0);

    logic                  w_clr_valid;
    logic [DWIDTH:0]       r_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    logic                  w_waddr_ok;
    logic                  w_raddr_ok;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wpar;
    logic [DWIDTH:0]       w_mem_rd;
    logic                  w_bypass_hit;
    logic [DWIDTH-1:0]     w_rd_data;
    logic                  w_rd_err;
    logic [1:0]            w_drop_inc;
    logic [DROP_CNT_W:0]   w_drop_sum;

    hqm_mem_pg_fsm #(
        .WAKE_CYCLES (WAKE_CYCLES)
    ) u_fsm (
        .clk             (clk),
        .rst             (rst),
        .pwr_req         (pwr_req),
        .pwr_enable_b_in (pwr_enable_b_in),
        .pwr_ack         (pwr_ack),
        .isol            (pgcb_isol_en),
        .en_b            (pwr_enable_b_out),
        .clr_valid       (w_clr_valid)
    );

    // Accesses are accepted only while powered and aimed at a real entry
    assign w_waddr_ok = ({1'b0, waddr} < c_depth);
    assign w_raddr_ok = ({1'b0, raddr} < c_depth);
    assign w_wr       = we & pwr_ack & w_waddr_ok;
    assign w_rd       = re & pwr_ack & w_raddr_ok;

    // Stored parity makes the whole entry even; injection flips it
    if (c_par_en) begin : g_par
        assign w_wpar = (^wdata) ^ par_inj;
    end else begin : g_nopar
        assign w_wpar = 1'b0;
    end

    assign w_mem_rd     = r_mem[raddr];
    assign w_bypass_hit = c_bypass_en && w_wr && (waddr == raddr);

    // Read result: bypassed write data, stored entry, or zero if never written
    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_bypass_hit) begin
            w_rd_data = wdata;
            w_rd_err  = par_inj & c_par_en;
        end else if (r_valid[raddr]) begin
            w_rd_data = w_mem_rd[DWIDTH-1:0];
            w_rd_err  = c_par_en & (^w_mem_rd);
        end
    end

    // Array storage, parity kept in the spare top bit
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[waddr] <= {w_wpar, wdata};
        end
    end

    // Valid bitmap, forgotten whenever the array loses power
    always_ff @(posedge clk) begin
        if (rst || w_clr_valid) begin
            r_valid <= '0;
        end else if (w_wr) begin
            r_valid[waddr] <= 1'b1;
        end
    end

    // One-cycle read pipe; data holds between reads, error is qualified
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            rpar_err <= 1'b0;
        end else begin
            rvalid   <= w_rd;
            rpar_err <= w_rd & w_rd_err;
            if (w_rd) begin
                rdata <= w_rd_data;
            end
        end
    end

    assign w_drop_inc = {1'b0, we & ~w_wr} + {1'b0, re & ~w_rd};
    assign w_drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(w_drop_inc);

    // Saturating count of rejected accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
        end
    end

endmodule : hqm_system_mem_rf_pg_seq
`default_nettype wire

// File: tb/tb_hqm_system_mem_rf_pg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hqm_system_mem_rf_pg_seq
//  Description : Self-checking bench for the power-gated RF wrapper. Two
//                instances (bypass on / off) share stimulus; a simple array
//                model and a two-stage power-chain echo drive expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hqm_system_mem_rf_pg_seq;

    localparam int DEPTH  = 4;
    localparam int DWIDTH = 17;
    localparam int WAKE   = 8;
    localparam int AWIDTH = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0;
    logic [AWIDTH-1:0] waddr = '0;
    logic [DWIDTH-1:0] wdata = '0;
    logic              par_inj = 1'b0;
    logic              re = 1'b0;
    logic [AWIDTH-1:0] raddr = '0;
    logic              pwr_req = 1'b0;
    logic              pwr_enable_b_in;

    logic [DWIDTH-1:0] rdata, rdata_n;
    logic              rvalid, rvalid_n;
    logic              rpar_err, rpar_err_n;
    logic              pwr_ack, pwr_ack_n;
    logic              pgcb_isol_en, pgcb_isol_en_n;
    logic              pwr_enable_b_out, pwr_enable_b_out_n;
    logic [7:0]        drop_cnt, drop_cnt_n;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DWIDTH-1:0] m_data  [DEPTH];
    bit                m_err   [DEPTH];
    bit                m_valid [DEPTH];
    bit                m_on = 1'b0;
    int                m_drop = 0;
    logic [DWIDTH-1:0] exp_rd_b = '0;
    logic [DWIDTH-1:0] exp_rd_n = '0;

    always #5 clk = ~clk;

    // Power chain: echo follows the enable two clocks later
    logic [1:0] r_chain;
    always @(posedge clk) begin
        if (rst) r_chain <= 2'b11;
        else     r_chain <= {r_chain[0], pwr_enable_b_out};
    end
    assign pwr_enable_b_in = r_chain[1];

    hqm_system_mem_rf_pg_seq #(
        .DEPTH(DEPTH), .DWIDTH(DWIDTH), .WAKE_CYCLES(WAKE), .PAR_EN(1), .BYPASS_EN(1)
    ) u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .par_inj(par_inj),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .rpar_err(rpar_err),
        .pwr_req(pwr_req), .pwr_ack(pwr_ack), .pgcb_isol_en(pgcb_isol_en),
        .pwr_enable_b_out(pwr_enable_b_out), .pwr_enable_b_in(pwr_enable_b_in),
        .drop_cnt(drop_cnt)
    );

    hqm_system_mem_rf_pg_seq #(
        .DEPTH(DEPTH), .DWIDTH(DWIDTH), .WAKE_CYCLES(WAKE), .PAR_EN(1), .BYPASS_EN(0)
    ) u_dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .par_inj(par_inj),
        .re(re), .raddr(raddr), .rdata(rdata_n), .rvalid(rvalid_n), .rpar_err(rpar_err_n),
        .pwr_req(pwr_req), .pwr_ack(pwr_ack_n), .pgcb_isol_en(pgcb_isol_en_n),
        .pwr_enable_b_out(pwr_enable_b_out_n), .pwr_enable_b_in(pwr_enable_b_in),
        .drop_cnt(drop_cnt_n)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pwr(input string tag, input bit ack, input bit isol, input bit enb);
        check_val({tag, "_ack"},    32'(pwr_ack),            32'(ack));
        check_val({tag, "_isol"},   32'(pgcb_isol_en),       32'(isol));
        check_val({tag, "_enb"},    32'(pwr_enable_b_out),   32'(enb));
        check_val({tag, "_ack_n"},  32'(pwr_ack_n),          32'(ack));
        check_val({tag, "_isol_n"}, 32'(pgcb_isol_en_n),     32'(isol));
        check_val({tag, "_enb_n"},  32'(pwr_enable_b_out_n), 32'(enb));
    endtask

    // One clock of access traffic, checked against the array model
    task automatic cyc(input bit we_i, input int wa, input logic [DWIDTH-1:0] wd,
                       input bit inj, input bit re_i, input int ra);
        bit exp_v;
        bit pe_b;
        bit pe_n;
        we      = we_i;
        waddr   = wa[AWIDTH-1:0];
        wdata   = wd;
        par_inj = inj;
        re      = re_i;
        raddr   = ra[AWIDTH-1:0];
        exp_v   = m_on && re_i;
        pe_b    = 1'b0;
        pe_n    = 1'b0;
        if (m_on) begin
            if (re_i) begin
                exp_rd_n = m_valid[ra] ? m_data[ra] : '0;
                pe_n     = m_valid[ra] && m_err[ra];
                if (we_i && (wa == ra)) begin
                    exp_rd_b = wd;
                    pe_b     = inj;
                end else begin
                    exp_rd_b = exp_rd_n;
                    pe_b     = pe_n;
                end
            end
            if (we_i) begin
                m_data[wa]  = wd;
                m_err[wa]   = inj;
                m_valid[wa] = 1'b1;
            end
        end else begin
            m_drop = m_drop + int'(we_i) + int'(re_i);
            if (m_drop > 255) m_drop = 255;
        end
        step();
        we = 1'b0; re = 1'b0; par_inj = 1'b0;
        check_val("rvalid",     32'(rvalid),     32'(exp_v));
        check_val("rvalid_n",   32'(rvalid_n),   32'(exp_v));
        check_val("rdata",      32'(rdata),      32'(exp_rd_b));
        check_val("rdata_n",    32'(rdata_n),    32'(exp_rd_n));
        check_val("rpar_err",   32'(rpar_err),   32'(pe_b));
        check_val("rpar_err_n", 32'(rpar_err_n), 32'(pe_n));
        check_val("drop_cnt",   32'(drop_cnt),   32'(m_drop));
    endtask

    // Raise request, wait for the echo, then time the wake delay exactly
    task automatic power_up();
        int n;
        pwr_req = 1'b1;
        n = 0;
        while (pwr_enable_b_in !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check_val("pwrup_echo_timeout", 32'(n < 20), 32'd1);
        check_val("pwrup_en_b", 32'(pwr_enable_b_out), 32'd0);
        step();
        check_pwr("wake_entry", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= WAKE; i++) begin
            step();
            check_val("wake_ack",  32'(pwr_ack),      32'(i == WAKE));
            check_val("wake_isol", 32'(pgcb_isol_en), 32'(i != WAKE));
        end
        m_on = 1'b1;
    endtask

    // Drop request (optionally with a read in the last powered cycle)
    task automatic power_down(input bit with_read, input int ra);
        int n;
        pwr_req = 1'b0;
        cyc(1'b0, 0, '0, 1'b0, with_read, ra);
        m_on = 1'b0;
        check_pwr("drain", 1'b0, 1'b0, 1'b0);
        step();
        check_pwr("isol", 1'b0, 1'b1, 1'b0);
        step();
        check_pwr("pwrdn", 1'b0, 1'b1, 1'b1);
        n = 0;
        while (pwr_enable_b_in !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_val("pwrdn_echo_timeout", 32'(n < 20), 32'd1);
        step();
        check_pwr("off", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0; m_err[i] = 1'b0; m_valid[i] = 1'b0;
        end

        // Reset state
        step(); step();
        check_pwr("reset", 1'b0, 1'b1, 1'b1);
        check_val("reset_rdata",  32'(rdata),    32'd0);
        check_val("reset_rvalid", 32'(rvalid),   32'd0);
        check_val("reset_perr",   32'(rpar_err), 32'd0);
        check_val("reset_drop",   32'(drop_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Power-up with wake timing
        power_up();

        // Write then read back
        cyc(1'b1, 2, 17'h1ABCD, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, '0, 1'b0, 1'b1, 2);
        check_val("rd_addr2", 32'(rdata), 32'h1ABCD);

        // Same-cycle write and read
        cyc(1'b1, 1, 17'h0AAAA, 1'b0, 1'b0, 0);
        cyc(1'b1, 1, 17'h00055, 1'b0, 1'b1, 1);
        check_val("bypass_on",  32'(rdata),   32'h00055);
        check_val("bypass_off", 32'(rdata_n), 32'h0AAAA);

        // Parity injection and recovery
        cyc(1'b1, 3, 17'h13579, 1'b1, 1'b0, 0);
        cyc(1'b0, 0, '0, 1'b0, 1'b1, 3);
        check_val("perr_inj", 32'(rpar_err), 32'd1);
        cyc(1'b1, 3, 17'h13579, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, '0, 1'b0, 1'b1, 3);
        check_val("perr_clean", 32'(rpar_err), 32'd0);

        // Random traffic while powered
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
                DWIDTH'($urandom), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)));
        end

        // Power down with a read in the last powered cycle, then re-power
        power_down(1'b1, 2);
        power_up();
        cyc(1'b0, 0, '0, 1'b0, 1'b1, 2);
        check_val("repower_rdata", 32'(rdata),    32'd0);
        check_val("repower_perr",  32'(rpar_err), 32'd0);

        // Dropped traffic while off saturates the counter
        power_down(1'b0, 0);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, int'($urandom_range(0, DEPTH-1)), DWIDTH'($urandom), 1'b0,
                1'b1, int'($urandom_range(0, DEPTH-1)));
        end
        check_val("drop_sat",   32'(drop_cnt),   32'd255);
        check_val("drop_sat_n", 32'(drop_cnt_n), 32'd255);

        // Reset during wake returns straight to the off controls
        pwr_req = 1'b1;
        begin
            int n;
            n = 0;
            while (pwr_enable_b_in !== 1'b0 && n < 20) begin
                step();
                n++;
            end
            check_val("rstwake_echo_timeout", 32'(n < 20), 32'd1);
        end
        step(); step(); step();
        check_pwr("in_wake", 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        m_drop = 0;
        check_pwr("rst_wake", 1'b0, 1'b1, 1'b1);
        check_val("rst_wake_drop",   32'(drop_cnt), 32'(m_drop));
        check_val("rst_wake_rvalid", 32'(rvalid),   32'd0);
        pwr_req = 1'b0;
        rst = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_hqm_system_mem_rf_pg_seq
`default_nettype wire
